// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential arithmetic blocks (divider and shift-add multiplier).
// State encodings are fixed so both blocks decode identically in the lab datapath.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } div_state_e;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  // Bits needed for an iteration counter that is loaded with w and counts down to zero.
  function automatic int unsigned count_bits(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {acc,q} left, trial-subtract the divisor,
// keep the difference and set the quotient bit only when it does not go negative.
module div_step #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH:0]   diff;
  logic             fits;

  always_comb begin
    shifted  = {acc, q[WIDTH-1]};
    fits     = (shifted >= {2'b00, divisor});
    diff     = shifted[WIDTH:0] - {1'b0, divisor};
    acc_next = fits ? diff : shifted[WIDTH:0];
    q_next   = {q[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring unsigned divider: one quotient bit per clock, registered
// quotient/remainder with a one-cycle done strobe and a divide-by-zero flag.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned CW = count_bits(WIDTH);

  div_state_e       state, state_next;
  logic [WIDTH:0]   acc, acc_next;
  logic [WIDTH-1:0] q, q_next;
  logic [WIDTH-1:0] dvs_r;
  logic [CW-1:0]    count;
  logic             last_iter;

  assign last_iter = (count == CW'(1));

  div_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .q        (q),
    .divisor  (dvs_r),
    .acc_next (acc_next),
    .q_next   (q_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (divisor == '0) ? DONE : DIVIDE;
      DIVIDE:  if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == DIVIDE) || (state == DONE);
    done = (state == DONE);
  end

  // Results load only on the final iteration (or at accept for divide-by-zero),
  // so the outputs never show partial quotients.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      q           <= '0;
      dvs_r       <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvs_r <= divisor;
            acc   <= '0;
            q     <= dividend;
            count <= CW'(WIDTH);
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        DIVIDE: begin
          acc   <= acc_next;
          q     <= q_next;
          count <= count - CW'(1);
          if (last_iter) begin
            quotient    <= q_next;
            remainder   <= acc_next[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider at WIDTH=4: directed vector table,
// multi-cycle corner sequences, and an exhaustive back-to-back sweep.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] dividend, divisor;
  logic [3:0] quotient, remainder;
  logic       busy, done, div_by_zero;

  int checks   = 0;
  int failures = 0;

  seq_divider #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] dvd;
    logic [3:0] dvs;
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
    int         lat;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts one op from an IDLE negedge; returns at the IDLE negedge after the done pulse.
  task automatic do_op(input string nm, input logic [3:0] dvd, input logic [3:0] dvs,
                       input logic [3:0] q_exp, input logic [3:0] r_exp,
                       input logic dbz_exp, input int lat_exp);
    int         lat;
    int         bad;
    logic [3:0] q_hold;
    lat = 0;
    bad = 0;
    q_hold = quotient;
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = ~dvd;
    divisor  = dvs + 4'd1;
    @(negedge clk);
    while (!done && lat < 40) begin
      if (!busy || quotient !== q_hold) bad++;
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, lat, lat_exp);
    chk({nm, "_quotient"}, quotient, q_exp);
    chk({nm, "_remainder"}, remainder, r_exp);
    chk({nm, "_dbz"}, div_by_zero, dbz_exp);
    chk({nm, "_busy_hold"}, bad, 0);
    @(negedge clk);
    chk({nm, "_done_one_cycle"}, done, 0);
    chk({nm, "_idle_after"}, busy, 0);
  endtask

  initial begin
    int         ndone;
    int         busy_bad;
    int         lat;
    logic [3:0] cq, cr;
    logic [3:0] eq, er;
    logic       edbz;

    vecs[0] = '{"d13_4", 4'd13, 4'd4, 4'd3,  4'd1, 1'b0, 4};
    vecs[1] = '{"d15_1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 4};
    vecs[2] = '{"d7_9",  4'd7,  4'd9, 4'd0,  4'd7, 1'b0, 4};
    vecs[3] = '{"d0_5",  4'd0,  4'd5, 4'd0,  4'd0, 1'b0, 4};
    vecs[4] = '{"d9_0",  4'd9,  4'd0, 4'hF,  4'd9, 1'b1, 0};
    vecs[5] = '{"d8_2",  4'd8,  4'd2, 4'd4,  4'd0, 1'b0, 4};

    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(negedge clk);
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_dbz", div_by_zero, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      do_op(vecs[i].name, vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].lat);

    // Start pulse during iteration 2 must be ignored.
    dividend = 4'd13;
    divisor  = 4'd4;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start    = 1'b1;
    dividend = 4'd6;
    divisor  = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    cq = '0;
    cr = '0;
    repeat (10) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        cq = quotient;
        cr = remainder;
      end
    end
    chk("ignore_start_done_count", ndone, 1);
    chk("ignore_start_quotient", cq, 3);
    chk("ignore_start_remainder", cr, 1);

    // Asynchronous reset in the middle of 14/3.
    dividend = 4'd14;
    divisor  = 4'd3;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_quotient", quotient, 0);
    chk("async_rst_remainder", remainder, 0);
    chk("async_rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("async_rst_no_done", ndone, 0);
    do_op("after_rst_14_3", 4'd14, 4'd3, 4'd4, 4'd2, 1'b0, 4);

    // Exhaustive sweep with start held high: each op is accepted in the IDLE cycle after DONE.
    busy_bad = 0;
    start = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        dividend = a[3:0];
        divisor  = b[3:0];
        lat = 0;
        @(negedge clk);
        while (!done && lat < 40) begin
          if (!busy) busy_bad++;
          @(negedge clk);
          lat++;
        end
        if (b == 0) begin
          eq = 4'hF;
          er = a[3:0];
          edbz = 1'b1;
        end else begin
          eq = 4'(a / b);
          er = 4'(a % b);
          edbz = 1'b0;
        end
        chk($sformatf("sweep_%0d_%0d", a, b),
            {lat[7:0], 3'b000, div_by_zero, quotient, remainder},
            {(b == 0) ? 8'd0 : 8'd4, 3'b000, edbz, eq, er});
        @(negedge clk);
      end
    end
    start = 1'b0;
    chk("sweep_busy_never_dropped", busy_bad, 0);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
